// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types and constants for the dcache refill controller and its line buffer.
package dcache_pkg;

    localparam int BEAT_COUNT        = 8;
    localparam int BEAT_BYTES        = 8;
    localparam int LINE_OFFSET_WIDTH = 6;
    localparam int BEAT_SHIFT        = $clog2(BEAT_BYTES);
    localparam int CNT_WIDTH         = $clog2(BEAT_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        FILL
    } refill_state_t;

endpackage

// File: rtl/dcache_refill_ctrl_line_buffer.sv
// One cache line of storage: parallel load, shift-out-low for write-back, shift-in-high for refill.
module dcache_line_buffer #(
    parameter int BLOCK_WIDTH = 512,
    parameter int BUS_WIDTH   = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_load_en,
    input  logic [BLOCK_WIDTH-1:0] i_load_data,
    input  logic                   i_shift_out_en,
    input  logic                   i_shift_in_en,
    input  logic [BUS_WIDTH-1:0]   i_shift_in_data,
    output logic [BLOCK_WIDTH-1:0] o_data
);

    logic [BLOCK_WIDTH-1:0] line_q;

    // NOTE: the wide line is reset too, so o_data_block is never X after reset.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            line_q <= '0;
        end else if (i_load_en) begin
            line_q <= i_load_data;
        end else if (i_shift_in_en) begin
            line_q <= {i_shift_in_data, line_q[BLOCK_WIDTH-1:BUS_WIDTH]};
        end else if (i_shift_out_en) begin
            line_q <= {{BUS_WIDTH{1'b0}}, line_q[BLOCK_WIDTH-1:BUS_WIDTH]};
        end
    end

    assign o_data = line_q;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// dcache miss handler: optional dirty-victim write-back, 8-beat line refill, one-cycle fill strobe.
// Define DCACHE_REFILL_PERF_EN to add saturating o_miss_count / o_wb_count outputs.
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int BUS_WIDTH   = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_mem_access,
    input  logic                   i_hit,
    input  logic                   i_dirty,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
    input  logic [BLOCK_WIDTH-1:0] i_data_block_wb,
    output logic                   o_stall,
    output logic                   o_block_we,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [BUS_WIDTH-1:0]   o_mem_wdata,
    input  logic                   i_mem_rvalid,
    input  logic [BUS_WIDTH-1:0]   i_mem_rdata
`ifdef DCACHE_REFILL_PERF_EN
    ,
    output logic [31:0]            o_miss_count,
    output logic [31:0]            o_wb_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEAT_COUNT - 1);

    refill_state_t          state_q;
    logic [CNT_WIDTH-1:0]   req_cnt_q;
    logic [CNT_WIDTH-1:0]   rsp_cnt_q;
    logic                   req_done_q;
    logic                   mem_req_valid_q;
    logic                   block_we_q;
    logic [ADDR_WIDTH-1:0]  refill_base_q;
    logic [ADDR_WIDTH-1:0]  wb_base_q;
    logic [ADDR_WIDTH-1:0]  beat_base_d;
    logic [ADDR_WIDTH-1:0]  beat_offset_d;
    logic [BLOCK_WIDTH-1:0] line_data;
    logic                   miss;
    logic                   req_fire;
    logic                   unused_offset_bits;

    assign miss     = i_mem_access & ~i_hit;
    assign req_fire = mem_req_valid_q & i_mem_req_ready;

    // The refill base drops the line offset; those request bits are deliberately ignored.
    assign unused_offset_bits = ^i_addr[LINE_OFFSET_WIDTH-1:0];

    // NOTE: state registers use <= only, so every branch sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q         <= IDLE;
            req_cnt_q       <= '0;
            rsp_cnt_q       <= '0;
            req_done_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            block_we_q      <= 1'b0;
            refill_base_q   <= '0;
            wb_base_q       <= '0;
        end else begin
            block_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        refill_base_q   <= {i_addr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH],
                                            {LINE_OFFSET_WIDTH{1'b0}}};
                        req_cnt_q       <= '0;
                        rsp_cnt_q       <= '0;
                        req_done_q      <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        if (i_dirty) begin
                            wb_base_q <= i_addr_wb;
                            state_q   <= WB;
                        end else begin
                            state_q <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (req_fire) begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                        if (req_cnt_q == LAST_BEAT) state_q <= REFILL;
                    end
                end
                REFILL: begin
                    // Request issue and response capture are independent and may coincide.
                    if (req_fire && !req_done_q) begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                        if (req_cnt_q == LAST_BEAT) begin
                            req_done_q      <= 1'b1;
                            mem_req_valid_q <= 1'b0;
                        end
                    end
                    if (i_mem_rvalid) begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        if (rsp_cnt_q == LAST_BEAT) begin
                            state_q    <= FILL;
                            block_we_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dcache_line_buffer #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .BUS_WIDTH   (BUS_WIDTH)
    ) u_line_buffer (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_load_en       ((state_q == IDLE) & miss & i_dirty),
        .i_load_data     (i_data_block_wb),
        .i_shift_out_en  ((state_q == WB) & req_fire),
        .i_shift_in_en   ((state_q == REFILL) & i_mem_rvalid),
        .i_shift_in_data (i_mem_rdata),
        .o_data          (line_data)
    );

    assign beat_base_d   = (state_q == WB) ? wb_base_q : refill_base_q;
    assign beat_offset_d = ADDR_WIDTH'({req_cnt_q, {BEAT_SHIFT{1'b0}}});

    assign o_stall         = (state_q != IDLE) | miss;
    assign o_block_we      = block_we_q;
    assign o_data_block    = line_data;
    assign o_mem_req_valid = mem_req_valid_q;
    assign o_mem_we        = (state_q == WB);
    assign o_mem_addr      = beat_base_d + beat_offset_d;
    assign o_mem_wdata     = line_data[BUS_WIDTH-1:0];

`ifdef DCACHE_REFILL_PERF_EN
    logic [31:0] miss_count_q;
    logic [31:0] wb_count_q;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else if ((state_q == IDLE) && miss) begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + 1'b1;
            if (i_dirty && (wb_count_q != '1)) wb_count_q <= wb_count_q + 1'b1;
        end
    end

    assign o_miss_count = miss_count_q;
    assign o_wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: IDLE decode table plus clean, dirty, backpressure, hit and reset sequences.
`timescale 1ns/1ps
module tb_dcache_refill_ctrl;

    localparam int AW = 64;
    localparam int BW = 512;
    localparam int DW = 64;

    typedef struct {
        logic acc;
        logic hit;
        logic dirty;
        logic exp_stall;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } beat_t;

    logic          i_clk = 1'b0;
    logic          i_arst = 1'b1;
    logic          i_mem_access = 1'b0;
    logic          i_hit = 1'b0;
    logic          i_dirty = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [AW-1:0] i_addr_wb = '0;
    logic [BW-1:0] i_data_block_wb = '0;
    logic          o_stall;
    logic          o_block_we;
    logic [BW-1:0] o_data_block;
    logic          o_mem_req_valid;
    logic          i_mem_req_ready = 1'b0;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_rvalid = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
`ifdef DCACHE_REFILL_PERF_EN
    logic [31:0]   o_miss_count;
    logic [31:0]   o_wb_count;
`endif

    dcache_refill_ctrl dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_mem_access    (i_mem_access),
        .i_hit           (i_hit),
        .i_dirty         (i_dirty),
        .i_addr          (i_addr),
        .i_addr_wb       (i_addr_wb),
        .i_data_block_wb (i_data_block_wb),
        .o_stall         (o_stall),
        .o_block_we      (o_block_we),
        .o_data_block    (o_data_block),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_rvalid    (i_mem_rvalid),
        .i_mem_rdata     (i_mem_rdata)
`ifdef DCACHE_REFILL_PERF_EN
        ,
        .o_miss_count    (o_miss_count),
        .o_wb_count      (o_wb_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Memory model state, written only by the model process.
    beat_t         log_q[$];
    logic [DW-1:0] pend_q[$];
    logic [BW-1:0] fill_q[$];
    int            rsp_delivered = 0;
    int            hold_obs = 0;
    int            hold_err = 0;
    int            inject_done = 0;
    bit            ready_phase = 1'b0;
    bit            was_stalled = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_wdata = '0;

    // Controls, written only by the main process.
    bit ready_toggle = 1'b0;
    bit addr_data = 1'b0;
    int inject_req = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory: acts at the falling edge; read data returns one cycle after acceptance.
    initial begin : mem_model
        forever begin
            @(negedge i_clk);
            if (i_arst) begin
                pend_q.delete();
                was_stalled = 1'b0;
            end
            if (was_stalled && o_mem_req_valid) begin
                hold_obs++;
                if (o_mem_addr !== held_addr || o_mem_wdata !== held_wdata) hold_err++;
            end
            was_stalled = 1'b0;
            if (inject_done != inject_req) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                inject_done++;
            end else if (pend_q.size() > 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = pend_q.pop_front();
                rsp_delivered++;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
            end
            ready_phase     = ~ready_phase;
            i_mem_req_ready = ready_toggle ? ready_phase : 1'b1;
            if (o_mem_req_valid && i_mem_req_ready && !i_arst) begin
                log_q.push_back('{we: o_mem_we, addr: o_mem_addr, wdata: o_mem_wdata});
                if (!o_mem_we) pend_q.push_back(addr_data ? o_mem_addr : {61'd0, o_mem_addr[5:3]});
            end else if (o_mem_req_valid) begin
                was_stalled = 1'b1;
                held_addr   = o_mem_addr;
                held_wdata  = o_mem_wdata;
            end
            if (o_block_we) fill_q.push_back(o_data_block);
        end
    end

    task automatic nstep();
        @(negedge i_clk);
        #2;
    endtask

    // Issues one miss, then counts stall cycles after the miss edge up to and including the fill.
    task automatic run_miss(input logic [AW-1:0] addr, input bit dirty, input logic [AW-1:0] wb_addr,
                            input logic [BW-1:0] wb_blk, output int stall_cnt);
        int guard;
        nstep();
        i_mem_access    = 1'b1;
        i_hit           = 1'b0;
        i_dirty         = dirty;
        i_addr          = addr;
        i_addr_wb       = wb_addr;
        i_data_block_wb = wb_blk;
        #1;
        check("miss_cycle_stall", o_stall, 1'b1);
        nstep();
        i_mem_access = 1'b0;
        i_dirty      = 1'b0;
        stall_cnt    = 0;
        guard        = 0;
        while (guard < 400) begin
            if (o_stall) stall_cnt++;
            if (o_block_we) break;
            nstep();
            guard++;
        end
        check("fill_seen", o_block_we, 1'b1);
        nstep();
        check("post_fill_stall", o_stall, 1'b0);
        check("post_fill_we", o_block_we, 1'b0);
    endtask

    task automatic check_fill(input string name, input int idx, input logic [AW-1:0] base, input bit use_addr);
        logic [BW-1:0] blk;
        logic [DW-1:0] want;
        int bad;
        bad = 0;
        blk = (idx < fill_q.size()) ? fill_q[idx] : '0;
        for (int k = 0; k < 8; k++) begin
            want = use_addr ? base + 64'(8 * k) : 64'(k);
            if (blk[64*k +: 64] !== want) begin
                bad++;
                $display("FAIL %s word %0d: got 0x%0h, want 0x%0h", name, k, blk[64*k +: 64], want);
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    vec_t          vecs[7];
    logic [BW-1:0] blk;
    logic [BW-1:0] blk_before;
    int            stall_cnt;
    int            log_base;
    int            fill_base;
    int            rsp_base;
    int            guard;
    int            late_bad;
    int            wb_bad;
    int            rd_bad;

    initial begin : main
        vecs[0] = '{acc: 1'b0, hit: 1'b0, dirty: 1'b0, exp_stall: 1'b0};
        vecs[1] = '{acc: 1'b0, hit: 1'b1, dirty: 1'b0, exp_stall: 1'b0};
        vecs[2] = '{acc: 1'b1, hit: 1'b1, dirty: 1'b0, exp_stall: 1'b0};
        vecs[3] = '{acc: 1'b1, hit: 1'b1, dirty: 1'b1, exp_stall: 1'b0};
        vecs[4] = '{acc: 1'b1, hit: 1'b0, dirty: 1'b0, exp_stall: 1'b1};
        vecs[5] = '{acc: 1'b1, hit: 1'b0, dirty: 1'b1, exp_stall: 1'b1};
        vecs[6] = '{acc: 1'b0, hit: 1'b0, dirty: 1'b1, exp_stall: 1'b0};

        repeat (3) nstep();
        check("rst_stall", o_stall, 1'b0);
        check("rst_req_valid", o_mem_req_valid, 1'b0);
        check("rst_block_we", o_block_we, 1'b0);
        check("rst_block_zero", |o_data_block, 1'b0);
`ifdef DCACHE_REFILL_PERF_EN
        check("rst_miss_count", o_miss_count, 0);
        check("rst_wb_count", o_wb_count, 0);
`endif
        nstep();
        i_arst = 1'b0;

        // IDLE decode: inputs are withdrawn before the next rising edge.
        for (int v = 0; v < 7; v++) begin
            nstep();
            i_mem_access = vecs[v].acc;
            i_hit        = vecs[v].hit;
            i_dirty      = vecs[v].dirty;
            #1;
            check($sformatf("vec%0d_stall", v), o_stall, vecs[v].exp_stall);
            check($sformatf("vec%0d_req_valid", v), o_mem_req_valid, 1'b0);
            check($sformatf("vec%0d_block_we", v), o_block_we, 1'b0);
            i_mem_access = 1'b0;
            i_hit        = 1'b0;
            i_dirty      = 1'b0;
        end

        // Clean miss, beat-index read data.
        addr_data = 1'b0;
        log_base  = log_q.size();
        fill_base = fill_q.size();
        run_miss(64'h1040, 1'b0, '0, '0, stall_cnt);
        check("clean_stall_cycles", stall_cnt, 10);
        check("clean_beats", log_q.size() - log_base, 8);
        rd_bad = 0;
        for (int k = 0; k < 8 && log_base + k < log_q.size(); k++)
            if (log_q[log_base+k].we !== 1'b0 || log_q[log_base+k].addr !== 64'h1040 + 64'(8 * k)) rd_bad++;
        check("clean_read_addrs", rd_bad, 0);
        check("clean_fill_count", fill_q.size() - fill_base, 1);
        check_fill("clean_fill", fill_base, '0, 1'b0);

        // Dirty miss: write-back first, then refill with address-tagged data.
        addr_data = 1'b1;
        for (int k = 0; k < 8; k++) blk[64*k +: 64] = 64'hA0 + 64'(k);
        log_base  = log_q.size();
        fill_base = fill_q.size();
        run_miss(64'h3058, 1'b1, 64'h2000, blk, stall_cnt);
        check("dirty_stall_cycles", stall_cnt, 18);
        check("dirty_beats", log_q.size() - log_base, 16);
        wb_bad = 0;
        rd_bad = 0;
        for (int k = 0; k < 8 && log_base + 8 + k < log_q.size(); k++) begin
            if (log_q[log_base+k].we !== 1'b1 || log_q[log_base+k].addr !== 64'h2000 + 64'(8 * k) ||
                log_q[log_base+k].wdata !== 64'hA0 + 64'(k)) wb_bad++;
            if (log_q[log_base+8+k].we !== 1'b0 || log_q[log_base+8+k].addr !== 64'h3040 + 64'(8 * k)) rd_bad++;
        end
        check("dirty_wb_beats", wb_bad, 0);
        check("dirty_read_beats", rd_bad, 0);
        check("dirty_fill_count", fill_q.size() - fill_base, 1);
        check_fill("dirty_fill", fill_base, 64'h3040, 1'b1);
`ifdef DCACHE_REFILL_PERF_EN
        check("perf_miss_count_2", o_miss_count, 2);
        check("perf_wb_count_1", o_wb_count, 1);
`endif

        // Backpressure: ready alternates, every beat must appear exactly once and in order.
        ready_toggle = 1'b1;
        for (int k = 0; k < 8; k++) blk[64*k +: 64] = 64'h1111_0000 + 64'(k);
        log_base  = log_q.size();
        fill_base = fill_q.size();
        hold_obs  = 0;
        run_miss(64'h7FF8, 1'b1, 64'h5540, blk, stall_cnt);
        ready_toggle = 1'b0;
        check("bp_beats", log_q.size() - log_base, 16);
        wb_bad = 0;
        rd_bad = 0;
        for (int k = 0; k < 8 && log_base + 8 + k < log_q.size(); k++) begin
            if (log_q[log_base+k].we !== 1'b1 || log_q[log_base+k].addr !== 64'h5540 + 64'(8 * k) ||
                log_q[log_base+k].wdata !== 64'h1111_0000 + 64'(k)) wb_bad++;
            if (log_q[log_base+8+k].we !== 1'b0 || log_q[log_base+8+k].addr !== 64'h7FC0 + 64'(8 * k)) rd_bad++;
        end
        check("bp_wb_beats", wb_bad, 0);
        check("bp_read_beats", rd_bad, 0);
        check("bp_hold_seen", hold_obs > 0, 1'b1);
        check("bp_hold_stable", hold_err, 0);
        check_fill("bp_fill", fill_base, 64'h7FC0, 1'b1);

        // Hits never start a transfer nor touch the line.
        blk_before = o_data_block;
        log_base   = log_q.size();
        for (int c = 0; c < 3; c++) begin
            nstep();
            i_mem_access    = 1'b1;
            i_hit           = 1'b1;
            i_dirty         = 1'b1;
            i_data_block_wb = '1;
            #1;
            check("hit_stall", o_stall, 1'b0);
            check("hit_req_valid", o_mem_req_valid, 1'b0);
        end
        nstep();
        i_mem_access = 1'b0;
        i_hit        = 1'b0;
        i_dirty      = 1'b0;
        check("hit_line_kept", o_data_block == blk_before, 1'b1);
        check("hit_no_beats", log_q.size() - log_base, 0);

        // Reset after three refill responses, then a late response in IDLE.
        rsp_base = rsp_delivered;
        nstep();
        i_mem_access = 1'b1;
        i_hit        = 1'b0;
        i_addr       = 64'h1040;
        nstep();
        i_mem_access = 1'b0;
        guard        = 0;
        while ((rsp_delivered - rsp_base) < 3 && guard < 100) begin
            nstep();
            guard++;
        end
        check("rst_mid_three_rsp", rsp_delivered - rsp_base, 3);
        nstep();
        check("rst_mid_in_refill", o_mem_req_valid, 1'b1);
        i_arst = 1'b1;
        #1;
        check("rst_mid_req_valid", o_mem_req_valid, 1'b0);
        check("rst_mid_stall", o_stall, 1'b0);
        check("rst_mid_block_zero", |o_data_block, 1'b0);
        fill_base = fill_q.size();
        nstep();
        i_arst = 1'b0;
        inject_req++;
        late_bad = 0;
        repeat (4) begin
            nstep();
            if (o_block_we || o_mem_req_valid || o_stall) late_bad++;
        end
        check("late_rsp_sent", inject_done, inject_req);
        check("late_rsp_ignored", late_bad, 0);
        check("late_no_fill", fill_q.size() - fill_base, 0);

        // Fresh miss after the abandoned one, near the top of the address space.
        log_base  = log_q.size();
        fill_base = fill_q.size();
        run_miss(64'hFFFF_FFFF_FFFF_FFC8, 1'b0, '0, '0, stall_cnt);
        check("post_rst_stall_cycles", stall_cnt, 10);
        check("post_rst_beats", log_q.size() - log_base, 8);
        check_fill("post_rst_fill", fill_base, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1);
`ifdef DCACHE_REFILL_PERF_EN
        check("perf_miss_count_final", o_miss_count, 1);
        check("perf_wb_count_final", o_wb_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
